// File: rtl/onchip_seq_pkg.sv
// Shared types and constants for the on-chip RAM request sequencer.
// Field widths are fixed here; the top-level ADDR_W/DATA_W parameters must match.
package onchip_seq_pkg;

  localparam int SEQ_ADDR_W = 10;
  localparam int SEQ_DATA_W = 32;
  localparam int BE_W       = SEQ_DATA_W / 8;
  localparam int RD_LATENCY = 2;

  typedef struct packed {
    logic                  write;
    logic [SEQ_ADDR_W-1:0] addr;
    logic [BE_W-1:0]       be;
    logic [SEQ_DATA_W-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic                  is_write;
    logic [SEQ_DATA_W-1:0] rdata;
  } rsp_t;

endpackage

// File: rtl/onchip_seq_fifo.sv
// Generic synchronous FIFO with registered occupancy count.
// Pushes when full and pops when empty are ignored.
module onchip_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Explicit wrap keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/onchip_mem_req_sequencer.sv
// Request sequencer in front of the single-port on-chip RAM (1-cycle read latency).
// Optional write acknowledgements are enabled with `ONCHIP_SEQ_WRITE_ACK_EN.
module onchip_mem_req_sequencer
  import onchip_seq_pkg::*;
#(
  parameter int ADDR_W    = SEQ_ADDR_W,
  parameter int DATA_W    = SEQ_DATA_W,
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  // Valid/ready on both ports: a transfer happens on a rising edge where
  // valid & ready are both high; valid holds its payload until then.
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_is_write,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

`ifdef ONCHIP_SEQ_WRITE_ACK_EN
  localparam bit WR_ACK = 1'b1;
`else
  localparam bit WR_ACK = 1'b0;
`endif

  localparam int CRD_W = $clog2(RSP_DEPTH + 1);

  req_t                           req_in;
  req_t                           req_head;
  rsp_t                           rsp_in;
  rsp_t                           rsp_head;
  logic                           req_full;
  logic                           req_empty;
  logic                           rsp_full;
  logic                           rsp_empty;
  logic [$clog2(REQ_DEPTH+1)-1:0] req_count;
  logic [$clog2(RSP_DEPTH+1)-1:0] rsp_count;
  logic                           ready_en;
  logic                           req_push;
  logic                           issue;
  logic                           issue_rsp;
  logic                           rsp_push;
  logic                           rsp_pop;
  logic [CRD_W-1:0]               credits;
  logic [RD_LATENCY-1:0]          vld_pipe;
  logic [RD_LATENCY-1:0]          wr_pipe;
  logic                           unused_status;

  assign req_in    = '{write: req_write, addr: req_addr, be: req_be, wdata: req_wdata};
  assign req_ready = ready_en & ~req_full;
  assign req_push  = req_valid & req_ready;

  onchip_seq_fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (req_push),
    .din     (req_in),
    .pop     (issue),
    .dout    (req_head),
    .full    (req_full),
    .empty   (req_empty),
    .count   (req_count)
  );

  // Fire-and-forget writes bypass the credit check; anything that will
  // produce a response must own a response-queue slot before it issues.
  assign issue     = ~req_empty & ((credits != '0) | (~WR_ACK & req_head.write));
  assign issue_rsp = issue & (WR_ACK | ~req_head.write);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) credits <= CRD_W'(RSP_DEPTH);
    else          credits <= credits - CRD_W'(issue_rsp) + CRD_W'(rsp_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_address    <= '0;
      mem_byteenable <= '1;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
    end else begin
      mem_chipselect <= issue;
      if (issue) begin
        mem_address    <= req_head.addr;
        mem_byteenable <= req_head.write ? req_head.be : '1;
        mem_write      <= req_head.write;
        mem_writedata  <= req_head.wdata;
      end
    end
  end

  // Stage 0 marks the issue edge, the last stage lines up with valid readdata.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      wr_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[RD_LATENCY-2:0], issue_rsp};
      wr_pipe  <= {wr_pipe[RD_LATENCY-2:0], issue_rsp & req_head.write};
    end
  end

  assign rsp_push        = vld_pipe[RD_LATENCY-1];
  assign rsp_in.is_write = wr_pipe[RD_LATENCY-1];
  assign rsp_in.rdata    = wr_pipe[RD_LATENCY-1] ? '0 : mem_readdata;

  onchip_seq_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (rsp_push),
    .din     (rsp_in),
    .pop     (rsp_pop),
    .dout    (rsp_head),
    .full    (rsp_full),
    .empty   (rsp_empty),
    .count   (rsp_count)
  );

  assign rsp_valid = ~rsp_empty;
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign rsp_rdata = rsp_valid ? rsp_head.rdata : '0;
  assign mem_clken = reset_n;

`ifdef ONCHIP_SEQ_WRITE_ACK_EN
  assign rsp_is_write = rsp_valid & rsp_head.is_write;
`else
  assign rsp_is_write = 1'b0;
`endif

  assign unused_status = ^{rsp_full, req_count, rsp_count, rsp_head.is_write};

endmodule
